// File: rtl/divide_sequencer.sv
// divide_sequencer: multi-cycle 32-bit integer divider for div/divu/rem/remu.
// One restoring-division step per cycle on operand magnitudes, with the
// signs fixed up on the final step. Divide-by-zero skips the CALC state.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   Start                 divide request (held while the instruction decodes)
//   IsSigned, IsRem       signed operation / return remainder instead of quotient
//   Dividend, Divisor     rs1 / rs2 operands
//   Result                registered quotient or remainder, held until next DONE
//   Stall                 combinational pipeline hold
//   Busy                  high while in CALC
//   Done                  one-cycle pulse, Result valid
//   DivByZero             last operation had Divisor == 0
module divide_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        IsSigned,
  input  logic        IsRem,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Result,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       rem_q;       // 33-bit partial remainder
  logic [W-1:0]     quo_q;       // quotient shift register, starts as |Dividend|
  logic [W-1:0]     dvsr_q;      // |Divisor|
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             sel_rem_q;
  logic [W-1:0]     result_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [W-1:0]     dvd_abs;
  logic [W-1:0]     dvs_abs;
  logic [W+1:0]     trial;
  logic [W:0]       rem_d;
  logic [W-1:0]     quo_d;
  logic [W-1:0]     quo_fix;
  logic [W-1:0]     rem_fix;
  logic [W-1:0]     final_d;

  // Operand magnitudes; 0x80000000 maps onto itself as an unsigned value
  always_comb begin
    dvd_abs = Dividend;
    dvs_abs = Divisor;
    if (IsSigned && Dividend[W-1]) dvd_abs = ~Dividend + W'(1);
    if (IsSigned && Divisor[W-1])  dvs_abs = ~Divisor + W'(1);
  end

  // One restoring step: shift in next dividend bit, keep the subtraction if it did not go negative
  always_comb begin
    trial = {rem_q, quo_q[W-1]} - {2'b00, dvsr_q};
    rem_d = {rem_q[W-1:0], quo_q[W-1]};
    quo_d = {quo_q[W-2:0], 1'b0};
    if (!trial[W+1]) begin
      rem_d = trial[W:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end
    quo_fix = neg_quo_q ? (~quo_d + W'(1)) : quo_d;
    rem_fix = neg_rem_q ? (~rem_d[W-1:0] + W'(1)) : rem_d[W-1:0];
    final_d = sel_rem_q ? rem_fix : quo_fix;
  end

  // Sequencer state, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (Divisor == '0) begin
              result_q <= IsRem ? Dividend : '1;
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= dvd_abs;
              dvsr_q    <= dvs_abs;
              neg_quo_q <= IsSigned & (Dividend[W-1] ^ Divisor[W-1]);
              neg_rem_q <= IsSigned & Dividend[W-1];
              sel_rem_q <= IsRem;
              cnt_q     <= CNT_W'(W);
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Counter reaches zero on this step: the 32nd iteration
          if (cnt_q == CNT_W'(1)) begin
            result_q <= final_d;
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the core retires the instruction; forced low during reset
  assign Stall     = ~rst & (((state_q == IDLE) & Start) | (state_q == CALC));
  assign Result    = result_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_divide_sequencer;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        IsSigned;
  logic        IsRem;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [31:0] Result;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic        DivByZero;

  int checks   = 0;
  int failures = 0;

  divide_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .IsSigned  (IsSigned),
    .IsRem     (IsRem),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Result    (Result),
    .Stall     (Stall),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain RISC-V M-extension semantics
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
    int sa;
    int sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (!s) return r ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    sa = int'(a);
    sb = int'(b);
    return r ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Called 1 time unit after a rising edge, with the DUT idle; that cycle is cycle 0
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic r);
    logic [31:0] exp;
    exp      = ref_div(a, b, s, r);
    Start    = 1'b1;
    IsSigned = s;
    IsRem    = r;
    Dividend = a;
    Divisor  = b;
    #1;
    check({tag, ".stall0"}, 32'(Stall), 32'd1);
    check({tag, ".done0"}, 32'(Done), 32'd0);
    if (b == 32'd0) begin
      @(posedge clk); #1;
      check({tag, ".dz_done"}, 32'(Done), 32'd1);
      check({tag, ".dz_stall"}, 32'(Stall), 32'd0);
      check({tag, ".dz_busy"}, 32'(Busy), 32'd0);
      check({tag, ".dz_flag"}, 32'(DivByZero), 32'd1);
      check({tag, ".dz_result"}, Result, exp);
    end else begin
      for (int c = 1; c <= 32; c++) begin
        @(posedge clk); #1;
        // Operands wander during CALC; only the latched copies may matter
        Dividend = $urandom;
        Divisor  = $urandom;
        IsSigned = 1'($urandom);
        IsRem    = 1'($urandom);
        check({tag, ".calc_stall"}, 32'(Stall), 32'd1);
        check({tag, ".calc_busy"}, 32'(Busy), 32'd1);
        check({tag, ".calc_done"}, 32'(Done), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, ".done"}, 32'(Done), 32'd1);
      check({tag, ".stall33"}, 32'(Stall), 32'd0);
      check({tag, ".busy33"}, 32'(Busy), 32'd0);
      check({tag, ".dz_flag"}, 32'(DivByZero), 32'd0);
      check({tag, ".result"}, Result, exp);
    end
    // Start still high in DONE must not restart; drop it for the following IDLE cycle
    @(posedge clk); #1;
    Start = 1'b0;
    #1;
    check({tag, ".idle_done"}, 32'(Done), 32'd0);
    check({tag, ".idle_busy"}, 32'(Busy), 32'd0);
    check({tag, ".idle_stall"}, 32'(Stall), 32'd0);
    check({tag, ".hold"}, Result, exp);
    @(posedge clk); #1;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    rst      = 1'b1;
    Start    = 1'b1;
    IsSigned = 1'b0;
    IsRem    = 1'b0;
    Dividend = 32'd100;
    Divisor  = 32'd7;
    @(posedge clk); @(posedge clk); #1;
    check("rst.result", Result, 32'd0);
    check("rst.stall", 32'(Stall), 32'd0);
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.dz", 32'(DivByZero), 32'd0);
    rst   = 1'b0;
    Start = 1'b0;
    @(posedge clk); #1;

    run_op("udivq", 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("udivr", 32'd100, 32'd7, 1'b0, 1'b1);
    run_op("sdivq", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_op("sdivr", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    run_op("dz_q", 32'h1234, 32'd0, 1'b0, 1'b0);
    run_op("dz_r", 32'h1234, 32'd0, 1'b0, 1'b1);
    run_op("dz_sq", 32'h8765_4321, 32'd0, 1'b1, 1'b0);
    run_op("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_op("umax", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op("usmall", 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("sneg", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);

    // Reset in the middle of 100/7, then a fresh 9/3 right after release
    Start    = 1'b1;
    IsSigned = 1'b0;
    IsRem    = 1'b0;
    Dividend = 32'd100;
    Divisor  = 32'd7;
    for (int c = 0; c < 10; c++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rmid.busy", 32'(Busy), 32'd0);
    check("rmid.stall", 32'(Stall), 32'd0);
    check("rmid.done", 32'(Done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rmid.hold_done", 32'(Done), 32'd0);
      check("rmid.hold_busy", 32'(Busy), 32'd0);
    end
    rst = 1'b0;
    run_op("after_rst", 32'd9, 32'd3, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        3:       rb = ~32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
